// File: rtl/enigma_pkg.sv
// Shared types and constants for the Enigma rotor datapath.
package enigma_pkg;

    localparam int unsigned ALPHA_LEN = 26;
    localparam int unsigned POS_W     = 5;
    localparam int unsigned CNT_W     = 16;

    typedef logic [ALPHA_LEN-1:0] letter_t;
    typedef logic [POS_W-1:0]     pos_t;

    localparam pos_t NOTCH_I   = 5'd16;
    localparam pos_t NOTCH_II  = 5'd4;
    localparam pos_t NOTCH_III = 5'd21;
    localparam pos_t POS_MAX   = pos_t'(ALPHA_LEN - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESSED = 1'b1
    } key_state_e;

    // Single conditional subtraction: enough for any 5-bit input.
    function automatic pos_t mod_alpha(input pos_t v);
        return (v >= pos_t'(ALPHA_LEN)) ? v - pos_t'(ALPHA_LEN) : v;
    endfunction

    function automatic logic is_onehot(input letter_t v);
        return (v != '0) && ((v & (v - letter_t'(1))) == '0);
    endfunction

endpackage

// File: rtl/rotor_pos_counter.sv
// Mod-26 rotor position register with load, step enable and registered notch flag.
module rotor_pos_counter
    import enigma_pkg::*;
#(
    parameter logic [4:0] NOTCH = NOTCH_III
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_en,
    input  logic [4:0] load_val,
    input  logic       step,
    output logic [4:0] pos,
    output logic       at_notch
);

    pos_t pos_nxt;

    // Load has priority over step.
    always_comb begin
        pos_nxt = pos;
        if (load_en) begin
            pos_nxt = mod_alpha(load_val);
        end else if (step) begin
            pos_nxt = (pos == POS_MAX) ? '0 : pos + pos_t'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos      <= '0;
            at_notch <= (NOTCH == 5'd0);
        end else begin
            pos      <= pos_nxt;
            at_notch <= (pos_nxt == NOTCH);
        end
    end

endmodule

// File: rtl/rotor_stepper.sv
// Key-press capture and three-rotor Enigma stepping with double step.
// Optional build macro STEP_COUNT_EN adds the key_count output.
module rotor_stepper
    import enigma_pkg::*;
#(
    parameter logic [4:0] NOTCH_L = NOTCH_I,
    parameter logic [4:0] NOTCH_M = NOTCH_II,
    parameter logic [4:0] NOTCH_R = NOTCH_III
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [25:0] key_in,
    input  logic        key_down,
    input  logic        load_en,
    input  logic [4:0]  load_l,
    input  logic [4:0]  load_m,
    input  logic [4:0]  load_r,
    output logic [4:0]  pos_l,
    output logic [4:0]  pos_m,
    output logic [4:0]  pos_r,
    output logic [25:0] letter_out,
    output logic        letter_vld,
    output logic        key_err
`ifdef STEP_COUNT_EN
    ,
    output logic [15:0] key_count
`endif
);

    key_state_e state, state_nxt;
    logic       do_step;
    logic       do_cap;
    logic       do_err;
    logic       notch_l, notch_m, notch_r;
    logic       step_l, step_m;
    logic       unused_status;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // A press is consumed on the IDLE->PRESSED edge; a simultaneous load suppresses it.
    always_comb begin
        state_nxt = state;
        do_step   = 1'b0;
        do_cap    = 1'b0;
        do_err    = 1'b0;
        case (state)
            IDLE: begin
                if (key_down) begin
                    state_nxt = PRESSED;
                    if (!load_en) begin
                        if (is_onehot(key_in)) begin
                            do_step = 1'b1;
                            do_cap  = 1'b1;
                        end else begin
                            do_err  = 1'b1;
                        end
                    end
                end
            end
            PRESSED: begin
                if (!key_down) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Notch flags reflect the pre-step positions, giving the middle-rotor double step.
    assign step_m = do_step && (notch_r || notch_m);
    assign step_l = do_step && notch_m;

    rotor_pos_counter #(.NOTCH(NOTCH_L)) u_left (
        .clk      (clk),
        .reset    (reset),
        .load_en  (load_en),
        .load_val (load_l),
        .step     (step_l),
        .pos      (pos_l),
        .at_notch (notch_l)
    );

    rotor_pos_counter #(.NOTCH(NOTCH_M)) u_middle (
        .clk      (clk),
        .reset    (reset),
        .load_en  (load_en),
        .load_val (load_m),
        .step     (step_m),
        .pos      (pos_m),
        .at_notch (notch_m)
    );

    rotor_pos_counter #(.NOTCH(NOTCH_R)) u_right (
        .clk      (clk),
        .reset    (reset),
        .load_en  (load_en),
        .load_val (load_r),
        .step     (do_step),
        .pos      (pos_r),
        .at_notch (notch_r)
    );

    // Left notch is status only; nothing downstream of it steps.
    assign unused_status = notch_l;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            letter_out <= '0;
            letter_vld <= 1'b0;
            key_err    <= 1'b0;
        end else begin
            if (do_cap) letter_out <= key_in;
            letter_vld <= do_cap;
            key_err    <= do_err;
        end
    end

`ifdef STEP_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        key_count <= '0;
        else if (load_en) key_count <= '0;
        else if (do_cap)  key_count <= key_count + CNT_W'(1);
    end
`endif

endmodule

// File: tb/tb_rotor_stepper.sv
// Self-checking bench for rotor_stepper against an arithmetic Enigma stepping model.
module tb_rotor_stepper;

    logic        clk = 1'b0;
    logic        reset;
    logic [25:0] key_in;
    logic        key_down;
    logic        load_en;
    logic [4:0]  load_l, load_m, load_r;
    logic [4:0]  pos_l, pos_m, pos_r;
    logic [25:0] letter_out;
    logic        letter_vld;
    logic        key_err;
`ifdef STEP_COUNT_EN
    logic [15:0] key_count;
`endif

    int total = 0;
    int bad   = 0;

    int          ml, mm, mr;
    logic [25:0] mlet;
    int          mcnt;

    rotor_stepper dut (
        .clk        (clk),
        .reset      (reset),
        .key_in     (key_in),
        .key_down   (key_down),
        .load_en    (load_en),
        .load_l     (load_l),
        .load_m     (load_m),
        .load_r     (load_r),
        .pos_l      (pos_l),
        .pos_m      (pos_m),
        .pos_r      (pos_r),
        .letter_out (letter_out),
        .letter_vld (letter_vld),
        .key_err    (key_err)
`ifdef STEP_COUNT_EN
        ,
        .key_count  (key_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic vld, input logic err);
        chk({tag, ".pos_l"}, 32'(pos_l), 32'(ml));
        chk({tag, ".pos_m"}, 32'(pos_m), 32'(mm));
        chk({tag, ".pos_r"}, 32'(pos_r), 32'(mr));
        chk({tag, ".letter"}, 32'(letter_out), 32'(mlet));
        chk({tag, ".vld"}, 32'(letter_vld), 32'(vld));
        chk({tag, ".err"}, 32'(key_err), 32'(err));
`ifdef STEP_COUNT_EN
        chk({tag, ".count"}, 32'(key_count), 32'(mcnt));
`endif
    endtask

    // Enigma stepping from the pre-step positions.
    task automatic model_step();
        int nl, nm, nr;
        nr = (mr + 1) % 26;
        nm = (mr == 21 || mm == 4) ? (mm + 1) % 26 : mm;
        nl = (mm == 4) ? (ml + 1) % 26 : ml;
        ml = nl; mm = nm; mr = nr;
    endtask

    function automatic int red(input int v);
        return (v >= 26) ? v - 26 : v;
    endfunction

    task automatic do_load(input int l, input int m, input int r);
        load_l = 5'(l); load_m = 5'(m); load_r = 5'(r);
        load_en = 1'b1;
        tick();
        load_en = 1'b0;
        ml = red(l); mm = red(m); mr = red(r); mcnt = 0;
        check_all("load", 1'b0, 1'b0);
    endtask

    task automatic press(input logic [25:0] k, input int hold, input string tag);
        logic ok;
        ok = ($countones(k) == 1);
        key_in = k;
        key_down = 1'b1;
        tick();
        if (ok) begin
            model_step();
            mlet = k;
            mcnt = (mcnt + 1) % 65536;
        end
        check_all(tag, ok, !ok);
        for (int i = 0; i < hold; i++) begin
            tick();
            check_all({tag, ".hold"}, 1'b0, 1'b0);
        end
        key_down = 1'b0;
        key_in = '0;
        tick();
        check_all({tag, ".rel"}, 1'b0, 1'b0);
    endtask

    initial begin
        logic [25:0] k;
        int          act;

        reset = 1'b1; key_in = '0; key_down = 1'b0; load_en = 1'b0;
        load_l = '0; load_m = '0; load_r = '0;
        ml = 0; mm = 0; mr = 0; mlet = '0; mcnt = 0;
        tick(); tick();
        check_all("reset", 1'b0, 1'b0);
        reset = 1'b0;
        tick(); tick();
        check_all("idle", 1'b0, 1'b0);

        do_load(0, 0, 0);
        press(26'h1, 1, "press_a");

        do_load(0, 3, 20);
        press(26'h4, 0, "dbl1");
        chk("dbl1.r", 32'(pos_r), 32'd21);
        press(26'h8, 0, "dbl2");
        chk("dbl2.m", 32'(pos_m), 32'd4);
        press(26'h10, 0, "dbl3");
        chk("dbl3.l", 32'(pos_l), 32'd1);
        chk("dbl3.m", 32'(pos_m), 32'd5);
        chk("dbl3.r", 32'(pos_r), 32'd23);

        do_load(0, 0, 25);
        press(26'h20, 10, "wrap_r");
        chk("wrap_r.r", 32'(pos_r), 32'd0);

        do_load(25, 25, 21);
        press(26'h40, 0, "wrap_m");
        do_load(25, 4, 0);
        press(26'h80, 0, "wrap_l");
        chk("wrap_l.l", 32'(pos_l), 32'd0);

        press(26'h3, 2, "bad2");
        press(26'h0, 0, "bad0");
        do_load(31, 26, 30);
        chk("modload.l", 32'(pos_l), 32'd5);
        chk("modload.r", 32'(pos_r), 32'd4);

        // load and press in the same cycle
        key_in = 26'h100; key_down = 1'b1;
        load_l = 5'd7; load_m = 5'd8; load_r = 5'd9; load_en = 1'b1;
        tick();
        load_en = 1'b0;
        ml = 7; mm = 8; mr = 9; mcnt = 0;
        check_all("ldpress", 1'b0, 1'b0);
        tick(); tick();
        check_all("ldpress.hold", 1'b0, 1'b0);
        key_down = 1'b0; key_in = '0;
        tick();
        check_all("ldpress.rel", 1'b0, 1'b0);

        // load while held
        key_in = 26'h200; key_down = 1'b1;
        tick();
        model_step(); mlet = 26'h200; mcnt = 1;
        check_all("ldheld.press", 1'b1, 1'b0);
        load_l = 5'd20; load_m = 5'd3; load_r = 5'd2; load_en = 1'b1;
        tick();
        load_en = 1'b0;
        ml = 20; mm = 3; mr = 2; mcnt = 0;
        check_all("ldheld.load", 1'b0, 1'b0);
        tick();
        check_all("ldheld.still", 1'b0, 1'b0);
        key_down = 1'b0; key_in = '0;
        tick();

        press(26'h1, 0, "cnt1");
        press(26'h2, 0, "cnt2");
        press(26'h4, 0, "cnt3");

        // reset mid-press, then key still down after release counts as a new press
        key_in = 26'h400; key_down = 1'b1;
        tick();
        model_step(); mlet = 26'h400; mcnt = mcnt + 1;
        check_all("rstpress", 1'b1, 1'b0);
        reset = 1'b1;
        #2;
        ml = 0; mm = 0; mr = 0; mlet = '0; mcnt = 0;
        check_all("rst.async", 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        model_step(); mlet = 26'h400; mcnt = 1;
        check_all("rst.repress", 1'b1, 1'b0);
        key_down = 1'b0; key_in = '0;
        tick();

        for (int it = 0; it < 120; it++) begin
            act = int'($urandom_range(9, 0));
            if (act <= 6) begin
                k = '0;
                k[$urandom_range(25, 0)] = 1'b1;
                press(k, int'($urandom_range(3, 0)), "rnd");
            end else if (act == 7) begin
                k = 26'($urandom) & 26'h3FFFFFF;
                if ($countones(k) == 1) k = k | 26'h1 | 26'h2000000;
                press(k, int'($urandom_range(2, 0)), "rnd_bad");
            end else begin
                do_load(int'($urandom_range(31, 0)), int'($urandom_range(31, 0)),
                        int'($urandom_range(31, 0)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
